// File: rtl/block_data_memory.sv
// Block-granular data memory behind the data cache: 64 x 32-bit blocks, fixed-latency
// read/write with a registered busywait handshake. Optional DMEM_STATS_EN adds access counters.
module block_data_memory #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  mem_address,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        mem_busywait
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic        start;
    logic        finish;
    logic [3:0]  count;
    logic        op_write;
    logic [5:0]  addr_q;
    logic [31:0] data_q;
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Exactly one request is accepted in IDLE; a simultaneous read+write is dropped.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_busywait <= 1'b0;
            mem_readdata <= 32'd0;
            count        <= 4'd0;
            op_write     <= 1'b0;
            addr_q       <= 6'd0;
            data_q       <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            if (start) begin
                op_write     <= mem_write;
                addr_q       <= mem_address;
                data_q       <= mem_writedata;
                mem_busywait <= 1'b1;
                count        <= LAT_M1;
            end else if (finish) begin
                mem_busywait <= 1'b0;
                if (op_write) begin
                    mem[addr_q] <= data_q;
                end else begin
                    mem_readdata <= mem[addr_q];
                end
            end else if (state == BUSY) begin
                count <= count - 4'd1;
            end
        end
    end

`ifdef DMEM_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (finish) begin
            if (op_write) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Directed + randomized bench for block_data_memory against an array-based reference model.
module tb_block_data_memory;

    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    block_data_memory #(.LATENCY(LAT), .DEPTH(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DMEM_STATS_EN
        ,
        .rd_count      (rd_count),
        .wr_count      (wr_count)
`endif
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] last_rd;
    int          rd_exp;
    int          wr_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        last_rd = 32'd0;
        rd_exp  = 0;
        wr_exp  = 0;
    endtask

    // Issue one access; returns the time of the sampling edge. Leaves the DUT back in IDLE.
    task automatic do_access(input bit is_wr, input logic [5:0] a, input logic [31:0] d,
                             output time samp);
        int n;
        mem_read      = !is_wr;
        mem_write     = is_wr;
        mem_address   = a;
        mem_writedata = d;
        @(posedge clock);
        samp = $time;
        #1;
        check("busy_rise", {31'd0, mem_busywait}, 32'd1);
        n = 0;
        while (mem_busywait && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("busy_len", 32'(n), 32'(LAT));
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (is_wr) begin
            ref_mem[a] = d;
            if (wr_exp < 16'hFFFF) wr_exp++;
        end else begin
            last_rd = ref_mem[a];
            if (rd_exp < 16'hFFFF) rd_exp++;
        end
        check(is_wr ? "rdata_hold" : "rdata", mem_readdata, last_rd);
        @(posedge clock);
        #1;
        check("done_idle", {31'd0, mem_busywait}, 32'd0);
    endtask

    initial begin
        time t0, t1;
        int  n;
        bit  wr;
        logic [5:0]  a;
        logic [31:0] d;

        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 6'd0; mem_writedata = 32'd0;
        model_reset();
        #12;
        check("rst_busy", {31'd0, mem_busywait}, 32'd0);
        check("rst_rdata", mem_readdata, 32'd0);
        #15 reset = 1'b1;
        @(posedge clock); #1;

        // Fresh read of an untouched block
        do_access(1'b0, 6'd9, 32'd0, t0);

        // Write then read back
        do_access(1'b1, 6'd42, 32'hDEADBEEF, t0);
        do_access(1'b0, 6'd42, 32'd0, t0);

        // Write-back followed immediately by refill
        do_access(1'b1, 6'd5, 32'h11223344, t0);
        do_access(1'b0, 6'd13, 32'd0, t1);
        check("b2b_gap", 32'((t1 - t0) / 10), 32'(LAT + 2));

        // Illegal simultaneous read+write
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 6'd3; mem_writedata = 32'hFFFF_FFFF;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (mem_busywait) n++;
        end
        check("illegal_busy", 32'(n), 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        do_access(1'b0, 6'd3, 32'd0, t0);

        // Reset during BUSY aborts the write
        mem_write = 1'b1; mem_address = 6'd7; mem_writedata = 32'hCAFEF00D;
        @(posedge clock); @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, mem_busywait}, 32'd0);
        check("abort_rdata", mem_readdata, 32'd0);
        mem_write = 1'b0;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        do_access(1'b0, 6'd7, 32'd0, t0);

        // Randomized traffic over a narrow address window to force reuse
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 15));
            d  = $urandom;
            do_access(wr, a, d, t0);
        end
        for (int k = 0; k < 16; k++) begin
            do_access(1'b0, 6'(k), 32'd0, t0);
        end

`ifdef DMEM_STATS_EN
        check("wr_count", {16'd0, wr_count}, 32'(wr_exp));
        check("rd_count", {16'd0, rd_count}, 32'(rd_exp));
        force dut.rd_count = 16'hFFFF;
        @(posedge clock); #1;
        release dut.rd_count;
        rd_exp = 16'hFFFF;
        do_access(1'b0, 6'd1, 32'd0, t0);
        check("rd_sat", {16'd0, rd_count}, 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
